// File: rtl/racl_error_log_ctrl.sv
// ----------------------------------------------------------------------------
// racl_error_log_ctrl
//
// Purpose:
//   Owns the single SoC-level RACL error log. Denial strobes from up to NumSrc
//   RACL-checking subordinates are arbitrated round-robin. One event is
//   captured into the log, overflow is flagged when more than one denial has
//   been seen since the last clear, and a saturating denial counter is kept.
//   A level interrupt stays high while the log holds a captured denial.
//
// Ports:
//   clk_i          - clock
//   rst_ni         - asynchronous active-low reset
//   err_valid_i    - per-source denial strobe (one cycle per denial)
//   err_role_i     - per-source RACL role, source k in slice k
//   err_uid_i      - per-source CTN UID, source k in slice k
//   err_read_i     - per-source access type (1 = read, 0 = write)
//   err_addr_i     - per-source request address, source k in slice k
//   clear_i        - one-cycle software clear of log and counter
//   log_valid_o    - log holds a captured denial
//   log_overflow_o - more than one denial seen since last clear
//   log_role_o     - captured role
//   log_uid_o      - captured UID
//   log_read_o     - captured access type
//   log_addr_o     - captured address
//   log_src_o      - index of the captured source
//   err_count_o    - saturating count of all denials since last clear
//   irq_o          - level interrupt, mirrors log_valid_o
// ----------------------------------------------------------------------------
module racl_error_log_ctrl #(
    parameter int NumSrc       = 4,
    parameter int AddrWidth    = 32,
    parameter int NrRaclBits   = 1,
    parameter int NrCtnUidBits = 1,
    parameter int CntWidth     = 8,
    localparam int SrcW        = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumSrc-1:0]              err_valid_i,
    input  logic [NumSrc*NrRaclBits-1:0]   err_role_i,
    input  logic [NumSrc*NrCtnUidBits-1:0] err_uid_i,
    input  logic [NumSrc-1:0]              err_read_i,
    input  logic [NumSrc*AddrWidth-1:0]    err_addr_i,
    input  logic                           clear_i,
    output logic                           log_valid_o,
    output logic                           log_overflow_o,
    output logic [NrRaclBits-1:0]          log_role_o,
    output logic [NrCtnUidBits-1:0]        log_uid_o,
    output logic                           log_read_o,
    output logic [AddrWidth-1:0]           log_addr_o,
    output logic [SrcW-1:0]                log_src_o,
    output logic [CntWidth-1:0]            err_count_o,
    output logic                           irq_o
);

    // Popcount needs enough bits to hold NumSrc; the counter sum is kept at
    // least one bit wider than the counter so saturation can be detected.
    localparam int PopW = $clog2(NumSrc + 1);
    localparam int SumW = ((CntWidth + 1) > (PopW + 1)) ? (CntWidth + 1) : (PopW + 1);
    localparam logic [CntWidth-1:0] CntMax = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e                    state_q;
    logic [SrcW-1:0]           rr_ptr_q;

    logic                      any_valid;
    int                        win_idx;
    logic [PopW-1:0]           pop;
    logic [SumW-1:0]           cnt_base;
    logic [SumW-1:0]           cnt_sum;
    logic [CntWidth-1:0]       cnt_next;
    logic [SrcW-1:0]           rr_next;
    logic [NrRaclBits-1:0]     win_role;
    logic [NrCtnUidBits-1:0]   win_uid;
    logic                      win_read;
    logic [AddrWidth-1:0]      win_addr;

    assign any_valid = |err_valid_i;

    // Round-robin search: walk the sources starting at rr_ptr and wrap around,
    // keeping the first asserted one. Only meaningful when any_valid is set.
    always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        win_idx = 0;
        for (int i = 0; i < NumSrc; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NumSrc) begin
                idx = idx - NumSrc;
            end
            if (!found && err_valid_i[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Pull the winner's sideband fields out of the packed per-source buses.
    always_comb begin
        win_role = err_role_i[win_idx*NrRaclBits +: NrRaclBits];
        win_uid  = err_uid_i[win_idx*NrCtnUidBits +: NrCtnUidBits];
        win_read = err_read_i[win_idx];
        win_addr = err_addr_i[win_idx*AddrWidth +: AddrWidth];
        rr_next  = (win_idx == NumSrc - 1) ? '0 : SrcW'(win_idx + 1);
    end

    // Count how many sources denied this cycle; drives both the overflow
    // decision on capture and the denial counter increment.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NumSrc; i++) begin
            pop = pop + PopW'(err_valid_i[i]);
        end
    end

    // The clear zeroes the base before this cycle's denials are added, so
    // denials arriving together with a clear are still counted.
    always_comb begin
        cnt_base = clear_i ? '0 : SumW'(err_count_o);
        cnt_sum  = cnt_base + SumW'(pop);
        cnt_next = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[CntWidth-1:0];
    end

    // Log FSM. A capture happens from EMPTY, or from HELD when a clear lands in
    // the same cycle as new events (the clear wins first, then the new events
    // are arbitrated as if the log were empty and the old overflow is lost).
    // Events while HELD without a clear only set overflow; the data is frozen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= EMPTY;
            rr_ptr_q       <= '0;
            log_valid_o    <= 1'b0;
            log_overflow_o <= 1'b0;
            log_role_o     <= '0;
            log_uid_o      <= '0;
            log_read_o     <= 1'b0;
            log_addr_o     <= '0;
            log_src_o      <= '0;
            irq_o          <= 1'b0;
        end else begin
            if (any_valid && (state_q == EMPTY || clear_i)) begin
                state_q        <= HELD;
                rr_ptr_q       <= rr_next;
                log_valid_o    <= 1'b1;
                log_overflow_o <= (pop > PopW'(1));
                log_role_o     <= win_role;
                log_uid_o      <= win_uid;
                log_read_o     <= win_read;
                log_addr_o     <= win_addr;
                log_src_o      <= SrcW'(win_idx);
                irq_o          <= 1'b1;
            end else if (any_valid) begin
                log_overflow_o <= 1'b1;
            end else if (clear_i) begin
                state_q        <= EMPTY;
                log_valid_o    <= 1'b0;
                log_overflow_o <= 1'b0;
                log_role_o     <= '0;
                log_uid_o      <= '0;
                log_read_o     <= 1'b0;
                log_addr_o     <= '0;
                log_src_o      <= '0;
                irq_o          <= 1'b0;
            end
        end
    end

    // Saturating denial counter, cleared together with the log.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_o <= '0;
        end else begin
            err_count_o <= cnt_next;
        end
    end

endmodule

// File: tb/tb_racl_error_log_ctrl.sv
// ----------------------------------------------------------------------------
// tb_racl_error_log_ctrl
//
// Directed testbench for racl_error_log_ctrl with the default parameters
// (NumSrc = 4, AddrWidth = 32, 1-bit role/UID, CntWidth = 8). Each scenario
// task drives its stimulus and compares outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_racl_error_log_ctrl;

    localparam int NumSrc    = 4;
    localparam int AddrWidth = 32;
    localparam int CntWidth  = 8;

    logic                        clk_i;
    logic                        rst_ni;
    logic [NumSrc-1:0]           err_valid_i;
    logic [NumSrc-1:0]           err_role_i;
    logic [NumSrc-1:0]           err_uid_i;
    logic [NumSrc-1:0]           err_read_i;
    logic [NumSrc*AddrWidth-1:0] err_addr_i;
    logic                        clear_i;
    logic                        log_valid_o;
    logic                        log_overflow_o;
    logic [0:0]                  log_role_o;
    logic [0:0]                  log_uid_o;
    logic                        log_read_o;
    logic [AddrWidth-1:0]        log_addr_o;
    logic [1:0]                  log_src_o;
    logic [CntWidth-1:0]         err_count_o;
    logic                        irq_o;

    int checks = 0;
    int errors = 0;

    racl_error_log_ctrl #(
        .NumSrc      (NumSrc),
        .AddrWidth   (AddrWidth),
        .NrRaclBits  (1),
        .NrCtnUidBits(1),
        .CntWidth    (CntWidth)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .err_valid_i   (err_valid_i),
        .err_role_i    (err_role_i),
        .err_uid_i     (err_uid_i),
        .err_read_i    (err_read_i),
        .err_addr_i    (err_addr_i),
        .clear_i       (clear_i),
        .log_valid_o   (log_valid_o),
        .log_overflow_o(log_overflow_o),
        .log_role_o    (log_role_o),
        .log_uid_o     (log_uid_o),
        .log_read_o    (log_read_o),
        .log_addr_o    (log_addr_o),
        .log_src_o     (log_src_o),
        .err_count_o   (err_count_o),
        .irq_o         (irq_o)
    );

    // 10 ns clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Present strobes for one clock edge, then sample 1 ns after that edge
    // and drop the strobes (sideband fields are scrambled to prove the DUT
    // samples them only in the capture cycle).
    task automatic pulse(input logic [NumSrc-1:0] v, input logic clr);
        err_valid_i = v;
        clear_i     = clr;
        @(posedge clk_i);
        #1;
        err_valid_i = '0;
        clear_i     = 1'b0;
        err_role_i  = 4'b1010;
        err_uid_i   = 4'b0101;
        err_read_i  = 4'b0110;
        err_addr_i  = {4{32'hDEAD_BEEF}};
    endtask

    task automatic set_src(input int k, input logic role, input logic uid,
                           input logic rd, input logic [AddrWidth-1:0] addr);
        err_role_i[k] = role;
        err_uid_i[k]  = uid;
        err_read_i[k] = rd;
        err_addr_i[k*AddrWidth +: AddrWidth] = addr;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        err_valid_i = '0;
        clear_i     = 1'b0;
        err_role_i  = '0;
        err_uid_i   = '0;
        err_read_i  = '0;
        err_addr_i  = '0;
        #2;
        checks++;
        if ({log_valid_o, log_overflow_o, log_role_o, log_uid_o, log_read_o,
             log_addr_o, log_src_o, err_count_o, irq_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: valid=%b ovf=%b addr=%h src=%0d cnt=%0d irq=%b, required all 0",
                     log_valid_o, log_overflow_o, log_addr_o, log_src_o, err_count_o, irq_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single_event();
        set_src(2, 1'b1, 1'b1, 1'b1, 32'h4000_0010);
        pulse(4'b0100, 1'b0);
        checks++;
        if ({log_valid_o, log_src_o, log_overflow_o, err_count_o, irq_o} !== {1'b1, 2'd2, 1'b0, 8'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL single_status: valid=%b src=%0d ovf=%b cnt=%0d irq=%b, required 1 2 0 1 1",
                     log_valid_o, log_src_o, log_overflow_o, err_count_o, irq_o);
        end
        checks++;
        if ({log_role_o, log_uid_o, log_read_o, log_addr_o} !== {1'b1, 1'b1, 1'b1, 32'h4000_0010}) begin
            errors++;
            $display("[TB] FAIL single_fields: role=%b uid=%b read=%b addr=%h, required 1 1 1 40000010",
                     log_role_o, log_uid_o, log_read_o, log_addr_o);
        end
        pulse(4'b0000, 1'b1);
        checks++;
        if ({log_valid_o, irq_o, err_count_o, log_addr_o, log_src_o, log_role_o} !== '0) begin
            errors++;
            $display("[TB] FAIL single_clear: valid=%b irq=%b cnt=%0d addr=%h src=%0d, required all 0",
                     log_valid_o, irq_o, err_count_o, log_addr_o, log_src_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_src(1, 1'b0, 1'b1, 1'b0, 32'h0000_1111);
        set_src(3, 1'b1, 1'b0, 1'b1, 32'h0000_3333);
        pulse(4'b1010, 1'b0);
        checks++;
        if ({log_valid_o, log_src_o, log_overflow_o, err_count_o, log_addr_o} !== {1'b1, 2'd1, 1'b1, 8'd2, 32'h0000_1111}) begin
            errors++;
            $display("[TB] FAIL simul_first: valid=%b src=%0d ovf=%b cnt=%0d addr=%h, required 1 1 1 2 00001111",
                     log_valid_o, log_src_o, log_overflow_o, err_count_o, log_addr_o);
        end
        pulse(4'b0000, 1'b1);
        set_src(1, 1'b0, 1'b1, 1'b0, 32'h0000_1111);
        set_src(3, 1'b1, 1'b0, 1'b1, 32'h0000_3333);
        pulse(4'b1010, 1'b0);
        checks++;
        if ({log_src_o, log_overflow_o, err_count_o, log_addr_o, log_role_o, log_read_o} !== {2'd3, 1'b1, 8'd2, 32'h0000_3333, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL simul_rr: src=%0d ovf=%b cnt=%0d addr=%h role=%b read=%b, required 3 1 2 00003333 1 1",
                     log_src_o, log_overflow_o, err_count_o, log_addr_o, log_role_o, log_read_o);
        end
        pulse(4'b0000, 1'b1);
    endtask

    task automatic test_event_while_held();
        set_src(0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        pulse(4'b0001, 1'b0);
        checks++;
        if ({log_src_o, log_addr_o, log_overflow_o, err_count_o} !== {2'd0, 32'h0000_0100, 1'b0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL held_capture: src=%0d addr=%h ovf=%b cnt=%0d, required 0 00000100 0 1",
                     log_src_o, log_addr_o, log_overflow_o, err_count_o);
        end
        set_src(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200);
        pulse(4'b0010, 1'b0);
        checks++;
        if ({log_valid_o, log_src_o, log_addr_o, log_read_o, log_overflow_o, err_count_o} !== {1'b1, 2'd0, 32'h0000_0100, 1'b1, 1'b1, 8'd2}) begin
            errors++;
            $display("[TB] FAIL held_frozen: valid=%b src=%0d addr=%h read=%b ovf=%b cnt=%0d, required 1 0 00000100 1 1 2",
                     log_valid_o, log_src_o, log_addr_o, log_read_o, log_overflow_o, err_count_o);
        end
    endtask

    task automatic test_clear_with_event();
        set_src(3, 1'b0, 1'b1, 1'b0, 32'h0000_0300);
        pulse(4'b1000, 1'b1);
        checks++;
        if ({log_valid_o, log_src_o, log_addr_o, log_overflow_o, err_count_o, log_uid_o, irq_o} !== {1'b1, 2'd3, 32'h0000_0300, 1'b0, 8'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL clear_event: valid=%b src=%0d addr=%h ovf=%b cnt=%0d uid=%b irq=%b, required 1 3 00000300 0 1 1 1",
                     log_valid_o, log_src_o, log_addr_o, log_overflow_o, err_count_o, log_uid_o, irq_o);
        end
    endtask

    task automatic test_saturation();
        pulse(4'b0000, 1'b1);
        for (int n = 1; n <= 300; n++) begin
            set_src(0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
            pulse(4'b0001, 1'b0);
            if (n == 254) begin
                checks++;
                if (err_count_o !== 8'd254) begin
                    errors++;
                    $display("[TB] FAIL sat_254: cnt=%0d, required 254", err_count_o);
                end
            end
        end
        checks++;
        if (err_count_o !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_300: cnt=%0d, required 255", err_count_o);
        end
        pulse(4'b0000, 1'b1);
        checks++;
        if ({err_count_o, log_valid_o, log_overflow_o} !== '0) begin
            errors++;
            $display("[TB] FAIL sat_clear: cnt=%0d valid=%b ovf=%b, required 0 0 0",
                     err_count_o, log_valid_o, log_overflow_o);
        end
        // Multi-source burst across the saturation point: 253 + 4 -> 255
        for (int n = 0; n < 253; n++) begin
            pulse(4'b0001, 1'b0);
        end
        pulse(4'b1111, 1'b0);
        checks++;
        if (err_count_o !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_burst: cnt=%0d, required 255", err_count_o);
        end
    endtask

    task automatic test_async_reset();
        pulse(4'b0000, 1'b1);
        for (int n = 0; n < 5; n++) begin
            set_src(2, 1'b1, 1'b1, 1'b1, 32'h0000_0222);
            pulse(4'b0100, 1'b0);
        end
        checks++;
        if ({log_valid_o, err_count_o} !== {1'b1, 8'd5}) begin
            errors++;
            $display("[TB] FAIL areset_pre: valid=%b cnt=%0d, required 1 5", log_valid_o, err_count_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({log_valid_o, log_overflow_o, log_role_o, log_uid_o, log_read_o,
             log_addr_o, log_src_o, err_count_o, irq_o} !== '0) begin
            errors++;
            $display("[TB] FAIL areset_async: valid=%b addr=%h src=%0d cnt=%0d irq=%b, required all 0",
                     log_valid_o, log_addr_o, log_src_o, err_count_o, irq_o);
        end
        // Release reset with an event already present in that cycle
        @(negedge clk_i);
        rst_ni = 1'b1;
        set_src(1, 1'b1, 1'b0, 1'b0, 32'h0000_0111);
        pulse(4'b0010, 1'b0);
        checks++;
        if ({log_valid_o, log_src_o, log_addr_o, err_count_o, log_overflow_o} !== {1'b1, 2'd1, 32'h0000_0111, 8'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL areset_release: valid=%b src=%0d addr=%h cnt=%0d ovf=%b, required 1 1 00000111 1 0",
                     log_valid_o, log_src_o, log_addr_o, err_count_o, log_overflow_o);
        end
    endtask

    task automatic test_rr_wrap();
        // Pointer is 2 after capturing src 1; search 2,3,0 picks src 0
        pulse(4'b0000, 1'b1);
        set_src(0, 1'b0, 1'b1, 1'b1, 32'h0000_0A00);
        set_src(1, 1'b1, 1'b0, 1'b0, 32'h0000_0A01);
        pulse(4'b0011, 1'b0);
        checks++;
        if ({log_src_o, log_addr_o, log_overflow_o, err_count_o} !== {2'd0, 32'h0000_0A00, 1'b1, 8'd2}) begin
            errors++;
            $display("[TB] FAIL rr_wrap: src=%0d addr=%h ovf=%b cnt=%0d, required 0 00000A00 1 2",
                     log_src_o, log_addr_o, log_overflow_o, err_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_simultaneous();
        test_event_while_held();
        test_clear_with_event();
        test_saturation();
        test_async_reset();
        test_rr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/racl_error_log_ctrl.md
Name: racl_error_log_ctrl

Overview:
- Collects RACL denial events from up to NumSrc RACL-checking subordinates (register-file and SRAM range checkers) and owns the single SoC-level RACL error log.
- Arbitrates simultaneous denials round-robin, captures one event into the log, flags overflow, and keeps a saturating denial count.
- Raises a level interrupt while the log is valid; software clears it.

Parameters:
- NumSrc, 4, number of denial sources (2..16).
- AddrWidth, 32, request address width (equals top_pkg TL_AW).
- NrRaclBits, 1, RACL role width.
- NrCtnUidBits, 1, CTN UID width.
- CntWidth, 8, denial counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- err_valid_i  in  NumSrc  per-source denial strobe, one cycle per denial.
- err_role_i  in  NumSrc*NrRaclBits  per-source RACL role; source k occupies slice k.
- err_uid_i  in  NumSrc*NrCtnUidBits  per-source CTN UID.
- err_read_i  in  NumSrc  per-source access type: 1 = read, 0 = write.
- err_addr_i  in  NumSrc*AddrWidth  per-source request address.
- clear_i  in  1  one-cycle software clear of log and counter.
- log_valid_o  out  1  log holds a captured denial.
- log_overflow_o  out  1  more than one denial seen since last clear.
- log_role_o  out  NrRaclBits  captured role.
- log_uid_o  out  NrCtnUidBits  captured UID.
- log_read_o  out  1  captured access type.
- log_addr_o  out  AddrWidth  captured address.
- log_src_o  out  max(1,clog2(NumSrc))  index of the captured source.
- err_count_o  out  CntWidth  saturating count of all denials since last clear.
- irq_o  out  1  equals log_valid_o.

Behaviour:
- Reset: every output is 0; rr_ptr = 0.
- All outputs are registered. A denial in cycle t is visible on the outputs in cycle t+1.
- Log FSM states are EMPTY (log_valid = 0) and HELD (log_valid = 1).
- EMPTY with any err_valid_i set:
  - Winner is the first asserted index found searching from rr_ptr upward, modulo NumSrc.
  - The winner's fields and index are captured. Go to HELD.
  - log_overflow = 1 if popcount(err_valid_i) > 1, else 0.
  - rr_ptr = (winner + 1) mod NumSrc.
- HELD with any err_valid_i set: log fields are unchanged, log_overflow is set to 1, rr_ptr is unchanged.
- HELD with clear_i and no err_valid_i: go to EMPTY. log_overflow = 0. Data fields are zeroed.
- clear_i together with err_valid_i:
  - The clear applies first, then the new events are arbitrated as from EMPTY.
  - The log ends HELD with the new winner. Overflow follows the popcount rule only; the prior overflow is discarded.
- clear_i in EMPTY with no events: no effect beyond clearing the counter.
- rr_ptr advances only on a capture.
- err_count:
  - Next value = (clear_i ? 0 : err_count) + popcount(err_valid_i).
  - The addition is done at CntWidth+1 bits and saturates at 2^CntWidth-1. The counter never wraps.
- Role, UID, read and address inputs are sampled only for the winner in the capture cycle. Sources need not hold them.
- Reset asserted mid-operation forces every output and rr_ptr to 0 asynchronously. Events in the reset-release cycle are captured normally.

Test Plan:
- Single event: src 2 pulses with role = 1, uid = 1, read = 1, addr = 0x4000_0010 -> next cycle log_valid = 1, src = 2, overflow = 0, count = 1, irq = 1.
- Simultaneous events: srcs 1 and 3 pulse in the same cycle with rr_ptr = 0 -> src 1 captured, overflow = 1, count = 2, rr_ptr = 2. Clear, then pulse srcs 1 and 3 again -> src 3 captured.
- Event while HELD: log holds src 0 at addr 0x100. Src 1 pulses at 0x200 -> addr stays 0x100, overflow = 1, count increments.
- Clear with a simultaneous event: log HELD with overflow = 1. clear_i and src 3 (addr 0x300) in the same cycle -> log_valid = 1, src = 3, addr = 0x300, overflow = 0, count = 1.
- Saturation: 300 single-source pulses with no clear, CntWidth = 8 -> count stops at 255. clear_i alone -> count = 0 and log EMPTY.
- Async reset asserted while HELD with count = 5 -> all outputs are 0 immediately, before the next clock edge.
